id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage RISC-V core. Sits directly downstream of the decode controller.
- Captures the decoded control bits (ALUSrc, MemtoReg, RegWrite, ALUop, jumpreg, Branch, jump, MemRead, MemWrite, Halt) and the ID datapath fields, and presents them to EX one cycle later.
- Implements stall (hold), flush (bubble insertion) and a halt-drain sequencer. The sequencer lets older instructions retire after a HALT, then freezes the core.

---
 rtl/id_ex_stage.sv | 150 +++++++++++++++
 tb/tb_id_ex_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush handling and a halt-drain sequencer
// that lets older instructions retire after HALT, then freezes the core.
module id_ex_stage #(
    parameter int DATA_W       = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_id,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ALUSrc,
    input  logic                  MemtoReg,
    input  logic                  RegWrite,
    input  logic                  jumpreg,
    input  logic                  Branch,
    input  logic                  jump,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  Halt,
    input  logic [1:0]            ALUop,
    input  logic [DATA_W-1:0]     pc_id,
    input  logic [DATA_W-1:0]     rd1_id,
    input  logic [DATA_W-1:0]     rd2_id,
    input  logic [DATA_W-1:0]     imm_id,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic [2:0]            funct3_id,
    input  logic [6:0]            funct7_id,
    output logic                  ALUSrc_ex,
    output logic                  MemtoReg_ex,
    output logic                  RegWrite_ex,
    output logic                  jumpreg_ex,
    output logic                  Branch_ex,
    output logic                  jump_ex,
    output logic                  MemRead_ex,
    output logic                  MemWrite_ex,
    output logic                  Halt_ex,
    output logic [1:0]            ALUop_ex,
    output logic [DATA_W-1:0]     pc_ex,
    output logic [DATA_W-1:0]     rd1_ex,
    output logic [DATA_W-1:0]     rd2_ex,
    output logic [DATA_W-1:0]     imm_ex,
    output logic [REG_ADDR_W-1:0] rs1_ex,
    output logic [REG_ADDR_W-1:0] rs2_ex,
    output logic [REG_ADDR_W-1:0] rd_ex,
    output logic [2:0]            funct3_ex,
    output logic [6:0]            funct7_ex,
    output logic                  valid_ex,
    output logic                  draining,
    output logic                  halted,
    output logic                  id_hold
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       hold, capture, take;

    // Outside RUN neither stall nor flush matter: every edge is a bubble.
    assign hold    = (state == RUN) & stall & ~flush;
    assign capture = (state == RUN) & ~stall & ~flush;
    assign take    = capture & valid_id;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (take && Halt) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = 4'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = HALTED;
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Data fields load on any non-held edge; controls are zero unless a real
    // instruction is captured, which makes every other edge a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUSrc_ex   <= 1'b0;
            MemtoReg_ex <= 1'b0;
            RegWrite_ex <= 1'b0;
            jumpreg_ex  <= 1'b0;
            Branch_ex   <= 1'b0;
            jump_ex     <= 1'b0;
            MemRead_ex  <= 1'b0;
            MemWrite_ex <= 1'b0;
            Halt_ex     <= 1'b0;
            ALUop_ex    <= 2'b0;
            valid_ex    <= 1'b0;
            pc_ex       <= '0;
            rd1_ex      <= '0;
            rd2_ex      <= '0;
            imm_ex      <= '0;
            rs1_ex      <= '0;
            rs2_ex      <= '0;
            rd_ex       <= '0;
            funct3_ex   <= '0;
            funct7_ex   <= '0;
        end else if (!hold) begin
            ALUSrc_ex   <= take & ALUSrc;
            MemtoReg_ex <= take & MemtoReg;
            RegWrite_ex <= take & RegWrite;
            jumpreg_ex  <= take & jumpreg;
            Branch_ex   <= take & Branch;
            jump_ex     <= take & jump;
            MemRead_ex  <= take & MemRead;
            MemWrite_ex <= take & MemWrite;
            Halt_ex     <= take & Halt;
            ALUop_ex    <= take ? ALUop : 2'b0;
            valid_ex    <= take;
            pc_ex       <= pc_id;
            rd1_ex      <= rd1_id;
            rd2_ex      <= rd2_id;
            imm_ex      <= imm_id;
            rs1_ex      <= rs1_id;
            rs2_ex      <= rs2_id;
            rd_ex       <= rd_id;
            funct3_ex   <= funct3_id;
            funct7_ex   <= funct7_id;
        end
    end

    assign draining = (state == DRAIN);
    assign halted   = (state == HALTED);
    // Gated by rst_n so the freeze request is also cleared while in reset.
    assign id_hold  = rst_n & (stall | (state != RUN));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a per-cycle reference model plus
// hand-computed literal checks around stall, flush and halt-drain.
module tb_id_ex_stage;
    localparam int DATA_W = 32;
    localparam int RAW    = 5;
    localparam int DRAIN  = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic valid_id, stall, flush;
    logic ALUSrc, MemtoReg, RegWrite, jumpreg, Branch, jump, MemRead, MemWrite, Halt;
    logic [1:0] ALUop;
    logic [DATA_W-1:0] pc_id, rd1_id, rd2_id, imm_id;
    logic [RAW-1:0] rs1_id, rs2_id, rd_id;
    logic [2:0] funct3_id;
    logic [6:0] funct7_id;

    logic ALUSrc_ex, MemtoReg_ex, RegWrite_ex, jumpreg_ex, Branch_ex, jump_ex;
    logic MemRead_ex, MemWrite_ex, Halt_ex;
    logic [1:0] ALUop_ex;
    logic [DATA_W-1:0] pc_ex, rd1_ex, rd2_ex, imm_ex;
    logic [RAW-1:0] rs1_ex, rs2_ex, rd_ex;
    logic [2:0] funct3_ex;
    logic [6:0] funct7_ex;
    logic valid_ex, draining, halted, id_hold;

    int total = 0;
    int bad   = 0;

    id_ex_stage #(.DATA_W(DATA_W), .REG_ADDR_W(RAW), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .stall(stall), .flush(flush),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .jumpreg(jumpreg),
        .Branch(Branch), .jump(jump), .MemRead(MemRead), .MemWrite(MemWrite), .Halt(Halt),
        .ALUop(ALUop), .pc_id(pc_id), .rd1_id(rd1_id), .rd2_id(rd2_id), .imm_id(imm_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id), .funct3_id(funct3_id),
        .funct7_id(funct7_id),
        .ALUSrc_ex(ALUSrc_ex), .MemtoReg_ex(MemtoReg_ex), .RegWrite_ex(RegWrite_ex),
        .jumpreg_ex(jumpreg_ex), .Branch_ex(Branch_ex), .jump_ex(jump_ex),
        .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex), .Halt_ex(Halt_ex),
        .ALUop_ex(ALUop_ex), .pc_ex(pc_ex), .rd1_ex(rd1_ex), .rd2_ex(rd2_ex),
        .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .funct3_ex(funct3_ex), .funct7_ex(funct7_ex), .valid_ex(valid_ex),
        .draining(draining), .halted(halted), .id_hold(id_hold)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what EX must hold after each edge.
    logic [10:0] m_ctrl;
    logic [31:0] m_pc, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic        m_valid, m_halted;
    int          drain_left;

    function automatic logic [10:0] in_ctrl();
        return {ALUSrc, MemtoReg, RegWrite, jumpreg, Branch, jump, MemRead, MemWrite, Halt, ALUop};
    endfunction

    task automatic model_load_data();
        m_pc = pc_id; m_rd1 = rd1_id; m_rd2 = rd2_id; m_imm = imm_id;
        m_rs1 = rs1_id; m_rs2 = rs2_id; m_rd = rd_id; m_f3 = funct3_id; m_f7 = funct7_id;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ctrl = '0; m_valid = 0; m_halted = 0; drain_left = 0;
            m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
            m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_f3 = '0; m_f7 = '0;
        end else if (m_halted || drain_left > 0) begin
            m_ctrl = '0; m_valid = 0; model_load_data();
            if (drain_left > 0) begin
                drain_left--;
                if (drain_left == 0) m_halted = 1;
            end
        end else if (flush) begin
            m_ctrl = '0; m_valid = 0; model_load_data();
        end else if (!stall) begin
            model_load_data();
            m_valid = valid_id;
            m_ctrl  = valid_id ? in_ctrl() : 11'd0;
            if (valid_id && Halt) drain_left = DRAIN;
        end
        #1;
        chk("ctrl", {ALUSrc_ex, MemtoReg_ex, RegWrite_ex, jumpreg_ex, Branch_ex, jump_ex,
                     MemRead_ex, MemWrite_ex, Halt_ex, ALUop_ex}, m_ctrl);
        chk("valid_ex", valid_ex, m_valid);
        chk("draining", draining, drain_left > 0);
        chk("halted", halted, m_halted);
        chk("id_hold", id_hold, rst_n & (stall | (drain_left > 0) | m_halted));
        if (m_valid) begin
            chk("pc_ex", pc_ex, m_pc);
            chk("rd1_ex", rd1_ex, m_rd1);
            chk("rd2_ex", rd2_ex, m_rd2);
            chk("imm_ex", imm_ex, m_imm);
            chk("regs_ex", {rs1_ex, rs2_ex, rd_ex}, {m_rs1, m_rs2, m_rd});
            chk("funct_ex", {funct3_ex, funct7_ex}, {m_f3, m_f7});
        end
    end

    task automatic clr_in();
        valid_id = 0; stall = 0; flush = 0;
        ALUSrc = 0; MemtoReg = 0; RegWrite = 0; jumpreg = 0; Branch = 0; jump = 0;
        MemRead = 0; MemWrite = 0; Halt = 0; ALUop = 2'b00;
        pc_id = '0; rd1_id = '0; rd2_id = '0; imm_id = '0;
        rs1_id = '0; rs2_id = '0; rd_id = '0; funct3_id = '0; funct7_id = '0;
    endtask

    task automatic add_instr(input logic [31:0] pc, input logic [4:0] rd);
        clr_in();
        valid_id = 1; RegWrite = 1; ALUop = 2'b10;
        pc_id = pc; rd1_id = 32'h5; rd2_id = 32'h6; rs1_id = 5'd1; rs2_id = 5'd2; rd_id = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        clr_in();
        #1;
        chk("lit_reset_valid", valid_ex, 0);
        chk("lit_reset_hold", id_hold, 0);
        repeat (2) @(negedge clk);
        chk("lit_reset_rd1", rd1_ex, 32'h0);
        rst_n = 1;

        // R-type pass-through
        clr_in();
        valid_id = 1; RegWrite = 1; ALUop = 2'b10; rd1_id = 32'h11; rd2_id = 32'h22;
        rd_id = 5'd5; rs1_id = 5'd3; rs2_id = 5'd4; pc_id = 32'h100; funct7_id = 7'h20;
        @(negedge clk);
        chk("lit_rtype_regwrite", RegWrite_ex, 1);
        chk("lit_rtype_aluop", ALUop_ex, 2'b10);
        chk("lit_rtype_rd1", rd1_ex, 32'h11);
        chk("lit_rtype_rd", rd_ex, 5'd5);
        chk("lit_rtype_valid", valid_ex, 1);

        // LW then two stalled cycles with different inputs
        clr_in();
        valid_id = 1; MemRead = 1; MemtoReg = 1; ALUSrc = 1; RegWrite = 1;
        imm_id = 32'h8; rd_id = 5'd7; pc_id = 32'h104;
        @(negedge clk);
        clr_in();
        stall = 1; valid_id = 1; MemWrite = 1; imm_id = 32'h63; rd_id = 5'd9; pc_id = 32'h108;
        @(negedge clk);
        chk("lit_stall1_imm", imm_ex, 32'h8);
        chk("lit_stall1_memread", MemRead_ex, 1);
        chk("lit_stall1_hold", id_hold, 1);
        @(negedge clk);
        chk("lit_stall2_imm", imm_ex, 32'h8);
        chk("lit_stall2_memwrite", MemWrite_ex, 0);
        add_instr(32'h10c, 5'd3);
        @(negedge clk);
        chk("lit_unstall_rd", rd_ex, 5'd3);
        chk("lit_unstall_memread", MemRead_ex, 0);

        // flush wins over stall
        clr_in();
        valid_id = 1; stall = 1; flush = 1; MemWrite = 1; ALUSrc = 1; pc_id = 32'h110;
        @(negedge clk);
        chk("lit_flush_memwrite", MemWrite_ex, 0);
        chk("lit_flush_valid", valid_ex, 0);

        // invalid ID slot gates controls
        add_instr(32'h114, 5'd6);
        valid_id = 0;
        @(negedge clk);
        chk("lit_novalid_regwrite", RegWrite_ex, 0);

        // flushed halt is discarded
        clr_in();
        valid_id = 1; Halt = 1; flush = 1;
        @(negedge clk);
        chk("lit_flushhalt_halt", Halt_ex, 0);
        add_instr(32'h118, 5'd8);
        @(negedge clk);
        chk("lit_flushhalt_draining", draining, 0);
        chk("lit_after_flushhalt_valid", valid_ex, 1);

        // stalled halt taken on the first unstalled edge, then full drain
        clr_in();
        valid_id = 1; Halt = 1; stall = 1;
        @(negedge clk);
        chk("lit_stallhalt_halt", Halt_ex, 0);
        chk("lit_stallhalt_draining", draining, 0);
        stall = 0;
        @(negedge clk);
        chk("lit_halt_ex", Halt_ex, 1);
        chk("lit_drain1", draining, 1);
        add_instr(32'h120, 5'd9);
        stall = 1;
        @(negedge clk);
        chk("lit_drain2", draining, 1);
        chk("lit_drain2_halt", Halt_ex, 0);
        chk("lit_drain2_regwrite", RegWrite_ex, 0);
        chk("lit_drain2_hold", id_hold, 1);
        stall = 0;
        @(negedge clk);
        chk("lit_drain3", draining, 1);
        chk("lit_drain3_valid", valid_ex, 0);
        @(negedge clk);
        chk("lit_halted", halted, 1);
        chk("lit_halted_draining", draining, 0);
        repeat (3) @(negedge clk);
        chk("lit_halted_sticky", halted, 1);
        chk("lit_halted_regwrite", RegWrite_ex, 0);

        // reset mid-drain
        rst_n = 0;
        clr_in();
        @(negedge clk);
        rst_n = 1;
        clr_in();
        valid_id = 1; Halt = 1;
        @(negedge clk);
        clr_in();
        @(negedge clk);
        chk("lit_middrain_draining", draining, 1);
        rst_n = 0;
        #1;
        chk("lit_async_draining", draining, 0);
        chk("lit_async_halted", halted, 0);
        chk("lit_async_hold", id_hold, 0);
        @(negedge clk);
        rst_n = 1;
        add_instr(32'h200, 5'd12);
        @(negedge clk);
        chk("lit_post_reset_regwrite", RegWrite_ex, 1);
        chk("lit_post_reset_rd", rd_ex, 5'd12);
        chk("lit_post_reset_halted", halted, 0);
        clr_in();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
